// File: rtl/block_renderer.sv
// Erase/draw renderer for the falling block plus full-screen clear on status change.
// Optional RENDER_STATS_EN adds frames_drawn and overrun outputs.
module block_renderer #(
  parameter int          BLOCK_W      = 8,
  parameter int          BLOCK_H      = 4,
  parameter int          SCREEN_W     = 160,
  parameter int          SCREEN_H     = 120,
  parameter logic [2:0]  BLOCK_COLOUR = 3'b111,
  parameter logic [2:0]  BG_COLOUR    = 3'b000,
  parameter logic [2:0]  OVER_COLOUR  = 3'b100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sync,
  input  logic       bypass_erase,
  input  logic [7:0] prev_x,
  input  logic [7:0] x,
  input  logic [6:0] y,
  input  logic [1:0] game_status,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done
`ifdef RENDER_STATS_EN
  ,
  output logic [7:0] frames_drawn,
  output logic       overrun
`endif
);

  localparam logic [8:0] LP_BW1 = 9'(BLOCK_W - 1);
  localparam logic [7:0] LP_BH1 = 8'(BLOCK_H - 1);
  localparam logic [8:0] LP_SW  = 9'(SCREEN_W);
  localparam logic [7:0] LP_SH  = 8'(SCREEN_H);
  localparam logic [8:0] LP_SW1 = 9'(SCREEN_W - 1);
  localparam logic [7:0] LP_SH1 = 8'(SCREEN_H - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ERASE,
    S_DRAW,
    S_CLEAR
  } state_t;

  state_t     r_state, w_state_n;
  logic [8:0] r_i, w_i_n;
  logic [7:0] r_j, w_j_n;
  logic [7:0] r_x, r_px;
  logic [6:0] r_y;
  logic       r_pend, w_pend_n;
  logic [1:0] r_last, w_last_n;
  logic       r_fin;
  logic       w_latch;
  logic       w_plot;
  logic       w_done;
  logic       w_dframe;
  logic [8:0] w_sx;
  logic [7:0] w_sy;
  logic [2:0] w_col;
  logic [7:0] w_base;

  always_comb begin
    w_state_n = r_state;
    w_i_n     = r_i;
    w_j_n     = r_j;
    w_pend_n  = r_pend;
    w_last_n  = r_last;
    w_latch   = 1'b0;
    w_plot    = 1'b0;
    w_done    = 1'b0;
    w_dframe  = 1'b0;
    w_sx      = '0;
    w_sy      = '0;
    w_col     = BG_COLOUR;
    w_base    = (r_state == S_ERASE) ? r_px : r_x;
    unique case (r_state)
      S_IDLE: begin
        if (game_status != r_last) begin
          w_state_n = S_CLEAR;
          w_last_n  = game_status;
          w_i_n     = '0;
          w_j_n     = '0;
          if (sync) w_pend_n = 1'b1;
        end else if (sync || r_pend) begin
          w_latch   = 1'b1;
          w_pend_n  = 1'b0;
          w_i_n     = '0;
          w_j_n     = '0;
          w_state_n = bypass_erase ? S_DRAW : S_ERASE;
        end
      end
      S_ERASE, S_DRAW: begin
        if (sync) w_pend_n = 1'b1;
        w_sx   = {1'b0, w_base} + r_i;
        w_sy   = {1'b0, r_y} + r_j;
        w_col  = (r_state == S_DRAW) ? BLOCK_COLOUR : BG_COLOUR;
        // Off-screen pixels are suppressed but still take their cycle.
        w_plot = (w_sx < LP_SW) && (w_sy < LP_SH);
        if (r_i == LP_BW1) begin
          w_i_n = '0;
          if (r_j == LP_BH1) begin
            w_j_n = '0;
            if (r_state == S_ERASE) begin
              w_state_n = S_DRAW;
            end else begin
              w_state_n = S_IDLE;
              w_done    = 1'b1;
              w_dframe  = 1'b1;
            end
          end else begin
            w_j_n = r_j + 8'd1;
          end
        end else begin
          w_i_n = r_i + 9'd1;
        end
      end
      S_CLEAR: begin
        if (sync) w_pend_n = 1'b1;
        if (game_status != r_last) begin
          // Status moved again: restart the wipe in the new colour.
          w_last_n = game_status;
          w_i_n    = '0;
          w_j_n    = '0;
        end else begin
          w_sx   = r_i;
          w_sy   = r_j;
          w_col  = (r_last == 2'b10) ? OVER_COLOUR : BG_COLOUR;
          w_plot = 1'b1;
          if (r_i == LP_SW1) begin
            w_i_n = '0;
            if (r_j == LP_SH1) begin
              w_j_n     = '0;
              w_state_n = S_IDLE;
              w_done    = 1'b1;
            end else begin
              w_j_n = r_j + 8'd1;
            end
          end else begin
            w_i_n = r_i + 9'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_i     <= '0;
      r_j     <= '0;
      r_pend  <= 1'b0;
      r_last  <= 2'b00;
      r_x     <= '0;
      r_px    <= '0;
      r_y     <= '0;
      r_fin   <= 1'b0;
      vga_x   <= '0;
      vga_y   <= '0;
      colour  <= BG_COLOUR;
      plot    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_i     <= w_i_n;
      r_j     <= w_j_n;
      r_pend  <= w_pend_n;
      r_last  <= w_last_n;
      if (w_latch) begin
        r_x  <= x;
        r_px <= prev_x;
        r_y  <= y;
      end
      r_fin   <= w_done;
      vga_x   <= w_sx[7:0];
      vga_y   <= w_sy[6:0];
      colour  <= w_col;
      plot    <= w_plot;
      busy    <= (w_state_n != S_IDLE);
      done    <= r_fin;
    end
  end

`ifdef RENDER_STATS_EN
  logic r_fin_frm;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fin_frm    <= 1'b0;
      frames_drawn <= '0;
      overrun      <= 1'b0;
    end else begin
      r_fin_frm <= w_dframe;
      if (r_fin && r_fin_frm) frames_drawn <= frames_drawn + 8'd1;
      if (sync && r_pend) overrun <= 1'b1;
    end
  end
`endif

endmodule
